// File: rtl/mod_desplazador_pkg.sv
// rtl/mod_desplazador_pkg.sv - shared operation and state encodings for the sequential shifter
package mod_desplazador_pkg;

    typedef enum logic [1:0] {
        MODE_SRL = 2'b00,
        MODE_SLL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_FIN   = 2'b10
    } state_e;

endpackage

// File: rtl/mod_desplazador_secuencial_if.sv
// rtl/mod_desplazador_secuencial_if.sv - request/result bundle between requester and shifter
interface mod_desplazador_secuencial_if #(
    parameter int WIDTH = 6
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             START;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] A;
    logic [AMT_W-1:0] SHAMT;
    logic [WIDTH-1:0] Y;
    logic             C;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, MODE, A, SHAMT,
        input  Y, C, BUSY, DONE
    );

    modport slave (
        input  START, MODE, A, SHAMT,
        output Y, C, BUSY, DONE
    );

endinterface

// File: rtl/mod_desplazador_paso.sv
// rtl/mod_desplazador_paso.sv - one single-bit shift/rotate step, purely combinational
module mod_desplazador_paso
    import mod_desplazador_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ejected
);

    always_comb begin
        dout    = din;
        ejected = 1'b0;
        case (mode)
            MODE_SRL: begin
                dout    = {1'b0, din[WIDTH-1:1]};
                ejected = din[0];
            end
            MODE_SLL: begin
                dout    = {din[WIDTH-2:0], 1'b0};
                ejected = din[WIDTH-1];
            end
            MODE_SRA: begin
                dout    = {din[WIDTH-1], din[WIDTH-1:1]};
                ejected = din[0];
            end
            MODE_ROR: begin
                dout    = {din[0], din[WIDTH-1:1]};
                ejected = din[0];
            end
            default: begin
                dout    = din;
                ejected = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mod_desplazador_secuencial.sv
// rtl/mod_desplazador_secuencial.sv - multi-cycle shifter, one bit per clock, SHAMT+1 cycle latency
module mod_desplazador_secuencial
    import mod_desplazador_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic CLK,
    input  logic RST_N,
    mod_desplazador_secuencial_if.slave bus
);

    localparam int AMT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             cw_q, cw_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;

    logic [WIDTH-1:0] step_val;
    logic             step_ej;

    mod_desplazador_paso #(.WIDTH(WIDTH)) u_paso (
        .mode    (mode_q),
        .din     (work_q),
        .dout    (step_val),
        .ejected (step_ej)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SRL;
            cnt_q   <= '0;
            work_q  <= '0;
            cw_q    <= 1'b0;
            y_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            cw_q    <= cw_d;
            y_q     <= y_d;
            c_q     <= c_d;
        end
    end

    // The running carry lives in cw_q so the visible C only changes at completion.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        cw_d    = cw_q;
        y_d     = y_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    work_d  = bus.A;
                    cnt_d   = bus.SHAMT;
                    mode_d  = mode_e'(bus.MODE);
                    cw_d    = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = step_val;
                    cw_d   = step_ej;
                    cnt_d  = cnt_q - AMT_W'(1);
                end else begin
                    y_d     = work_q;
                    c_d     = cw_q;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.Y    = y_q;
    assign bus.C    = c_q;
    assign bus.BUSY = (state_q != ST_IDLE);
    assign bus.DONE = (state_q == ST_FIN);

endmodule

// File: tb/tb_mod_desplazador_secuencial.sv
// tb/tb_mod_desplazador_secuencial.sv - directed self-checking bench for the sequential shifter
module tb_mod_desplazador_secuencial;

    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_fail;

    mod_desplazador_secuencial_if #(.WIDTH(6)) bus ();

    mod_desplazador_secuencial #(.WIDTH(6)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [5:0] a,
                          input logic [2:0] sh, input logic [5:0] ey, input logic ec);
        int lat;
        int busy_cnt;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.MODE  = m;
        bus.A     = a;
        bus.SHAMT = sh;
        @(posedge CLK);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                // START held high with new operands while busy must be ignored
                bus.A     = ~a;
                bus.SHAMT = sh + 3'd3;
                bus.MODE  = m + 2'd1;
            end else begin
                bus.START = 1'b0;
            end
            if (bus.DONE) lat = k;
            else if (bus.BUSY) busy_cnt++;
        end
        check_eq({tag, "_latency"}, lat, int'(sh) + 1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, int'(sh) + 1);
        check_eq({tag, "_y"}, int'(bus.Y), int'(ey));
        check_eq({tag, "_c"}, int'(bus.C), int'(ec));
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        check_eq({tag, "_idle_after_fin"}, int'(bus.BUSY), 0);
        check_eq({tag, "_done_one_cycle"}, int'(bus.DONE), 0);
        check_eq({tag, "_y_hold"}, int'(bus.Y), int'(ey));
        check_eq({tag, "_c_hold"}, int'(bus.C), int'(ec));
    endtask

    initial begin
        int done_seen;
        n_checks  = 0;
        n_fail    = 0;
        RST_N     = 1'b0;
        bus.START = 1'b0;
        bus.MODE  = 2'b00;
        bus.A     = '0;
        bus.SHAMT = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_y", int'(bus.Y), 0);
        check_eq("rst_c", int'(bus.C), 0);
        check_eq("rst_busy", int'(bus.BUSY), 0);
        check_eq("rst_done", int'(bus.DONE), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_op("srl_a2d_s2", 2'b00, 6'b101101, 3'd2, 6'b001011, 1'b0);
        run_op("sra_a24_s3", 2'b10, 6'b100100, 3'd3, 6'b111100, 1'b1);
        run_op("ror_a01_s7", 2'b11, 6'b000001, 3'd7, 6'b100000, 1'b1);
        run_op("sll_a3f_s7", 2'b01, 6'b111111, 3'd7, 6'b000000, 1'b0);
        run_op("sll_a3f_s0", 2'b01, 6'b111111, 3'd0, 6'b111111, 1'b0);

        @(negedge CLK);
        bus.START = 1'b1;
        bus.MODE  = 2'b00;
        bus.A     = 6'b101010;
        bus.SHAMT = 3'd5;
        @(posedge CLK);
        @(negedge CLK);
        bus.A = 6'b111000;
        @(negedge CLK);
        bus.START = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_eq("midrst_y", int'(bus.Y), 0);
        check_eq("midrst_c", int'(bus.C), 0);
        check_eq("midrst_busy", int'(bus.BUSY), 0);
        check_eq("midrst_done", int'(bus.DONE), 0);
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 2) RST_N = 1'b1;
            if (bus.DONE || bus.BUSY) done_seen++;
        end
        check_eq("midrst_no_done", done_seen, 0);

        run_op("srl_a06_s1", 2'b00, 6'b000110, 3'd1, 6'b000011, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
